// File: rtl/mul_div.sv
// mul_div: 32-bit iterative multiply/divide unit (shift-add multiply, restoring divide on magnitudes).
// Define MUL_DIV_DIVIDE_EN to build the divide path; without it DIV/DIVU finish at once with overflow set.
module mul_div (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        busy,
    output logic        ready,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic [31:0] a_mag;
    logic [63:0] acc;
    logic        neg_hi;
`ifdef MUL_DIV_DIVIDE_EN
    logic        neg_lo;
    logic        is_div;
`endif

    logic        accept, short_op, a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic [32:0] mul_sum;
    logic [63:0] acc_step, acc_neg;
    logic [31:0] fix_hi, fix_lo;

    assign accept = start && (state == IDLE || state == DONE);
    assign a_neg  = ~op[0] & dataa[31];
    assign b_neg  = ~op[0] & datab[31];
    assign a_abs  = a_neg ? (~dataa + 32'd1) : dataa;
    assign b_abs  = b_neg ? (~datab + 32'd1) : datab;
    assign busy   = (state == CALC) || (state == FIX);
    assign ready  = (state == DONE);

    // Divide-by-zero (or any divide when the divider is not built) bypasses the iteration.
`ifdef MUL_DIV_DIVIDE_EN
    assign short_op = op[1] && (dataa == 32'd0);
`else
    assign short_op = op[1];
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_next = short_op ? DONE : CALC;
                else
                    state_next = IDLE;
            end
            CALC:    if (count == 5'd31) state_next = FIX;
            FIX:     state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
        acc_step = {mul_sum, acc[31:1]};
`ifdef MUL_DIV_DIVIDE_EN
        if (is_div) begin
            if (acc[63:31] >= {1'b0, a_mag})
                acc_step = {acc[62:31] - a_mag, acc[30:0], 1'b1};
            else
                acc_step = {acc[62:0], 1'b0};
        end
`endif
    end

    always_comb begin
        acc_neg          = ~acc + 64'd1;
        {fix_hi, fix_lo} = neg_hi ? acc_neg : acc;
`ifdef MUL_DIV_DIVIDE_EN
        if (is_div) begin
            fix_lo = neg_lo ? acc_neg[31:0] : acc[31:0];
            fix_hi = neg_hi ? (~acc[63:32] + 32'd1) : acc[63:32];
        end
`endif
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            count    <= 5'd0;
            a_mag    <= 32'd0;
            acc      <= 64'd0;
            neg_hi   <= 1'b0;
`ifdef MUL_DIV_DIVIDE_EN
            neg_lo   <= 1'b0;
            is_div   <= 1'b0;
`endif
            hi       <= 32'd0;
            lo       <= 32'd0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        count  <= 5'd0;
                        a_mag  <= a_abs;
                        acc    <= {32'd0, b_abs};
                        neg_hi <= op[1] ? b_neg : (a_neg ^ b_neg);
`ifdef MUL_DIV_DIVIDE_EN
                        neg_lo <= a_neg ^ b_neg;
                        is_div <= op[1];
`endif
                        if (short_op) begin
                            overflow <= 1'b1;
`ifdef MUL_DIV_DIVIDE_EN
                            hi <= datab;
                            lo <= 32'hFFFF_FFFF;
`else
                            hi <= 32'd0;
                            lo <= 32'd0;
`endif
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_step;
                    count <= count + 5'd1;
                end
                FIX: begin
                    hi       <= fix_hi;
                    lo       <= fix_lo;
                    overflow <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div.sv
// tb_mul_div: directed self-checking bench for mul_div; divide expectations follow MUL_DIV_DIVIDE_EN.
module tb_mul_div;

    logic        clk;
    logic        clrn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        busy;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] last_hi;
    logic [31:0] last_lo;

`ifdef MUL_DIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    mul_div dut (
        .clk      (clk),
        .clrn     (clrn),
        .start    (start),
        .op       (op),
        .dataa    (dataa),
        .datab    (datab),
        .busy     (busy),
        .ready    (ready),
        .hi       (hi),
        .lo       (lo),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; the request is taken on the following rising edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        dataa = a;
        datab = b;
        @(posedge clk);
    endtask

    // latency = index of the edge (after acceptance) that first samples ready high.
    task automatic waitReady(output int latency, output int busy_cycles);
        latency     = -1;
        busy_cycles = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = 1'b0;
            op    = ~op;
            dataa = ~dataa;
            datab = datab ^ 32'h5A5A_A5A5;
            if (busy) busy_cycles++;
            if (ready) begin
                latency = n;
                break;
            end
        end
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input int exp_busy,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_ovf);
        int lat, bc;
        applyStimulus(o, a, b);
        waitReady(lat, bc);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
        checkOutput({tag, "_hi"}, hi, exp_hi);
        checkOutput({tag, "_lo"}, lo, exp_lo);
        checkOutput({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
        @(negedge clk);
        checkOutput({tag, "_ready_pulse"}, {31'd0, ready}, 32'd0);
        checkOutput({tag, "_hi_hold"}, hi, exp_hi);
        last_hi = exp_hi;
        last_lo = exp_lo;
    endtask

    initial begin
        int lat, bc, ready_seen;

        clrn  = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        dataa = 32'd0;
        datab = 32'd0;
        repeat (2) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_ready", {31'd0, ready}, 32'd0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
        clrn = 1'b1;
        @(negedge clk);

        $display("[TB] multiply vectors");
        runOp("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        runOp("mult_neg", MULT, 32'hFFFF_FFFD, 32'h0000_0007, 34, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        runOp("mult_minmin", MULT, 32'h8000_0000, 32'h8000_0000, 34, 33, 32'h4000_0000, 32'h0000_0000, 1'b0);
        runOp("mult_negneg", MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 34, 33, 32'h0000_0000, 32'h0000_001E, 1'b0);
        runOp("multu_big", MULTU, 32'h8000_0000, 32'h0000_0003, 34, 33, 32'h0000_0001, 32'h8000_0000, 1'b0);

        $display("[TB] divide vectors");
        runOp("div_neg", DIV, 32'h0000_0002, 32'hFFFF_FFF9, DIV_EN ? 34 : 1, DIV_EN ? 33 : 0,
              DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_EN ? 32'hFFFF_FFFD : 32'd0, !DIV_EN);
        runOp("divu", DIVU, 32'd7, 32'd100, DIV_EN ? 34 : 1, DIV_EN ? 33 : 0,
              DIV_EN ? 32'd2 : 32'd0, DIV_EN ? 32'd14 : 32'd0, !DIV_EN);
        runOp("div_minint", DIV, 32'hFFFF_FFFF, 32'h8000_0000, DIV_EN ? 34 : 1, DIV_EN ? 33 : 0,
              32'd0, DIV_EN ? 32'h8000_0000 : 32'd0, !DIV_EN);
        runOp("div_negdivisor", DIV, 32'hFFFF_FFFE, 32'd7, DIV_EN ? 34 : 1, DIV_EN ? 33 : 0,
              DIV_EN ? 32'd1 : 32'd0, DIV_EN ? 32'hFFFF_FFFD : 32'd0, !DIV_EN);
        runOp("divu_zero", DIVU, 32'd0, 32'h0000_1234, 1, 0,
              DIV_EN ? 32'h0000_1234 : 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1'b1);

        $display("[TB] ignored start and reset abort");
        applyStimulus(MULTU, 32'd5, 32'd6);
        ready_seen = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = (n == 10);
            op    = MULT;
            dataa = 32'd3;
            datab = 32'd4;
            if (ready) ready_seen++;
        end
        checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
        checkOutput("abort_no_ready", 32'(ready_seen), 32'd0);
        checkOutput("abort_hi_hold", hi, last_hi);
        checkOutput("abort_lo_hold", lo, last_lo);
        clrn = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_ready", {31'd0, ready}, 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        checkOutput("abort_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        runOp("restart", MULTU, 32'd5, 32'd6, 34, 33, 32'd0, 32'd30, 1'b0);

        $display("[TB] back-to-back");
        applyStimulus(MULTU, 32'd11, 32'd3);
        waitReady(lat, bc);
        checkOutput("b2b_first_latency", 32'(lat), 32'd34);
        checkOutput("b2b_first_lo", lo, 32'd33);
        applyStimulus(MULTU, 32'd7, 32'd9);
        #1;
        checkOutput("b2b_busy_next", {31'd0, busy}, 32'd1);
        checkOutput("b2b_ready_next", {31'd0, ready}, 32'd0);
        waitReady(lat, bc);
        checkOutput("b2b_second_latency", 32'(lat), 32'd34);
        checkOutput("b2b_second_lo", lo, 32'd63);
        checkOutput("b2b_second_hi", hi, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mul_div.md
MUL_DIV -- requirements
Module: mul_div

Interface
REQ-001 SHALL have ports (clock and reset first):
  clk  in  1  rising-edge clock
  clrn  in  1  asynchronous active-low reset
  start  in  1  request strobe, sampled on clk rising edge
  op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU (matches ALU unit-11 alufunc[1:0])
  dataa  in  32  multiplicand / divisor
  datab  in  32  multiplier / dividend
  busy  out  1  operation in progress
  ready  out  1  one-cycle pulse: hi/lo/overflow valid
  hi  out  32  product[63:32] / remainder
  lo  out  32  product[31:0] / quotient
  overflow  out  1  divide by zero
REQ-002 SHALL use one clock, clk; reset SHALL be asynchronous and active-low on clrn.
REQ-003 SHALL have no parameters; all widths fixed at 32/64.

Function
REQ-004 SHALL use states IDLE, CALC, FIX, DONE.
REQ-005 SHALL accept a request on an edge where start=1 and state is IDLE or DONE; it SHALL latch op, dataa and datab on that edge.
REQ-006 SHALL ignore start while state is CALC or FIX; the request SHALL be dropped, with no queuing.
REQ-007 After acceptance, the FSM SHALL stay in CALC for exactly 32 edges, one iteration per edge (shift-add multiply, restoring divide on magnitudes), driven by a 5-bit counter.
REQ-008 After CALC, the FSM SHALL spend one edge in FIX applying sign correction for signed ops, then enter DONE.
REQ-009 ready SHALL be 1 only in DONE, i.e. exactly 34 edges after the accepting edge, for one cycle.
REQ-010 From DONE, the FSM SHALL return to IDLE unless a new start is accepted.
REQ-011 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-012 hi, lo and overflow SHALL update only on the edge that enters DONE and SHALL hold until the next entry into DONE.
REQ-013 MULT/MULTU: {hi,lo} SHALL equal the full 64-bit signed/unsigned product of dataa and datab; overflow SHALL be 0.
REQ-014 DIV/DIVU: lo SHALL equal datab / dataa and hi SHALL equal datab % dataa (dividend datab, divisor dataa, ALU operand order).
REQ-015 Signed divide SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-016 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0, overflow=0.
REQ-017 DIV/DIVU with dataa=0 SHALL skip CALC/FIX and go IDLE/DONE->DONE on the accepting edge, with lo=0xFFFFFFFF, hi=datab, overflow=1.
REQ-018 Inputs SHALL be don't-care after the accepting edge; later changes SHALL NOT affect the result.

Reset
REQ-019 clrn=0 SHALL immediately force state=IDLE, counter=0, busy=0, ready=0, overflow=0, hi=0, lo=0, and all working registers to 0.
REQ-020 Reset during CALC/FIX SHALL abort the operation with no ready pulse; the first start after clrn returns high SHALL be accepted normally.

Configuration
REQ-021 Macro MUL_DIV_DIVIDE_EN SHALL control the divide path.
REQ-022 With MUL_DIV_DIVIDE_EN defined, DIV/DIVU SHALL be implemented per REQ-014..017.
REQ-023 Without MUL_DIV_DIVIDE_EN, no divider logic SHALL be synthesised; DIV/DIVU SHALL go directly to DONE on the accepting edge with hi=0, lo=0, overflow=1, while MULT/MULTU are unchanged.

Verification
REQ-024 MULTU dataa=datab=0xFFFFFFFF -> ready at edge 34, hi=0xFFFFFFFE, lo=0x00000001, overflow=0.
REQ-025 MULT dataa=0xFFFFFFFD (-3), datab=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-026 DIV datab=0xFFFFFFF9 (-7), dataa=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU datab=100, dataa=7 -> lo=14, hi=2.
REQ-027 DIVU dataa=0, datab=0x1234 -> ready one edge after acceptance, overflow=1, lo=0xFFFFFFFF, hi=0x1234, busy never 1.
REQ-028 Start MULTU 5*6, pulse start with other operands at CALC edge 10, then drop clrn at CALC edge 20 -> second start ignored (hi/lo unchanged), reset clears all outputs, no ready pulse; restart 5*6 -> lo=30, hi=0.
REQ-029 Back-to-back: start held at 1 in DONE -> new operation accepted that edge, busy=1 next cycle, second ready 34 edges later; build without MUL_DIV_DIVIDE_EN -> DIV returns overflow=1, hi=lo=0 in one edge.
